// File: rtl/vlc_pkg.sv
// Shared VLC definitions: exp-Golomb decoder state encoding and datapath widths.
package vlc_pkg;

    localparam int unsigned MAX_SUM_W = 32;
    localparam int unsigned LEN_W     = 7;
    localparam int unsigned Q_W       = 6;
    localparam int unsigned K_W       = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_SUFFIX,
        S_SIGN,
        S_DONE,
        S_ERR
    } egd_state_t;

endpackage

// File: rtl/bit_shift_accum.sv
// Suffix shifter for the exp-Golomb sum plus the remaining-suffix-bit counter.
module bit_shift_accum
    import vlc_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [Q_W-1:0]       i_load_rem,
    input  logic                 i_shift,
    input  logic                 i_bit,
    output logic [MAX_SUM_W-1:0] o_sum_nxt_c,
    output logic [Q_W-1:0]       o_rem
);

    logic [MAX_SUM_W-1:0] r_sum;
    logic [Q_W-1:0]       r_rem;
    logic [Q_W-1:0]       w_rem_nxt;

    // Load plants the leading 1 of the sum; each suffix bit shifts in below it.
    always_comb begin
        o_sum_nxt_c = r_sum;
        w_rem_nxt   = r_rem;
        if (i_clear) begin
            o_sum_nxt_c = '0;
            w_rem_nxt   = '0;
        end else if (i_load) begin
            o_sum_nxt_c = MAX_SUM_W'(1);
            w_rem_nxt   = i_load_rem;
        end else if (i_shift) begin
            o_sum_nxt_c = {r_sum[MAX_SUM_W-2:0], i_bit};
            w_rem_nxt   = r_rem - Q_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum <= '0;
            r_rem <= '0;
        end else begin
            r_sum <= o_sum_nxt_c;
            r_rem <= w_rem_nxt;
        end
    end

    assign o_rem = r_rem;

endmodule

// File: rtl/exp_golomb_decode.sv
// Bit-serial exp-Golomb decoder: counts the zero prefix, shifts in the suffix,
// optionally captures a trailing sign bit, and reports value and codeword length.
module exp_golomb_decode
    import vlc_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [K_W-1:0]       i_k,
    input  logic                 i_is_ac_level,
    input  logic                 i_bit_in,
    input  logic                 i_bit_valid,
    output logic                 o_bit_ready,
    output logic [MAX_SUM_W-1:0] o_val,
    output logic                 o_is_minus,
    output logic [LEN_W-1:0]     o_codeword_length,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_error
);

    egd_state_t r_state;
    egd_state_t w_state_nxt;
    egd_state_t w_tail_state;

    logic [K_W-1:0]       r_k;
    logic                 r_ac;
    logic [Q_W-1:0]       r_q;
    logic [LEN_W-1:0]     r_len;
    logic                 r_bit_ready;
    logic                 r_out_valid;
    logic                 r_error;
    logic                 r_is_minus;
    logic [MAX_SUM_W-1:0] r_val;
    logic [LEN_W-1:0]     r_codeword_length;

    logic                 w_accept;
    logic                 w_clear;
    logic                 w_q_inc;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_sign;
    logic [Q_W-1:0]       w_q_plus1;
    logic [Q_W-1:0]       w_rem_init;
    logic [Q_W-1:0]       w_rem;
    logic [MAX_SUM_W-1:0] w_sum_nxt;

    assign w_accept     = i_bit_valid && r_bit_ready;
    assign w_q_plus1    = r_q + Q_W'(1);
    assign w_rem_init   = r_q + Q_W'(r_k);
    assign w_tail_state = r_ac ? S_SIGN : S_DONE;

    bit_shift_accum u_accum (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_load_rem  (w_rem_init),
        .i_shift     (w_shift),
        .i_bit       (i_bit_in),
        .o_sum_nxt_c (w_sum_nxt),
        .o_rem       (w_rem)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Prefix overflow fires when the sum would need more than MAX_SUM_W bits.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_q_inc     = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_sign      = 1'b0;
        unique case (r_state)
            S_IDLE, S_ERR: begin
                if (i_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_PREFIX;
                end
            end
            S_PREFIX: begin
                if (w_accept) begin
                    if (!i_bit_in) begin
                        w_q_inc = 1'b1;
                        if (w_q_plus1 == Q_W'(MAX_SUM_W) - Q_W'(r_k)) w_state_nxt = S_ERR;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = (w_rem_init == '0) ? w_tail_state : S_SUFFIX;
                    end
                end
            end
            S_SUFFIX: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    if (w_rem == Q_W'(1)) w_state_nxt = w_tail_state;
                end
            end
            S_SIGN: begin
                if (w_accept) begin
                    w_sign      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_k               <= '0;
            r_ac              <= 1'b0;
            r_q               <= '0;
            r_len             <= '0;
            r_bit_ready       <= 1'b0;
            r_out_valid       <= 1'b0;
            r_error           <= 1'b0;
            r_is_minus        <= 1'b0;
            r_val             <= '0;
            r_codeword_length <= '0;
        end else begin
            r_bit_ready <= (w_state_nxt == S_PREFIX) || (w_state_nxt == S_SUFFIX) ||
                           (w_state_nxt == S_SIGN);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_error     <= (w_state_nxt == S_ERR);
            if (w_clear) begin
                r_k        <= i_k;
                r_ac       <= i_is_ac_level;
                r_q        <= '0;
                r_len      <= '0;
                r_is_minus <= 1'b0;
            end else begin
                if (w_q_inc)  r_q        <= w_q_plus1;
                if (w_accept) r_len      <= r_len + LEN_W'(1);
                if (w_sign)   r_is_minus <= i_bit_in;
            end
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_val             <= w_sum_nxt - (MAX_SUM_W'(1) << r_k);
                r_codeword_length <= r_len + LEN_W'(1);
            end
        end
    end

    assign o_bit_ready       = r_bit_ready;
    assign o_out_valid       = r_out_valid;
    assign o_error           = r_error;
    assign o_is_minus        = r_is_minus;
    assign o_val             = r_val;
    assign o_codeword_length = r_codeword_length;

endmodule
